// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the mem_responder word memory.
// Signal names keep the _i/_o suffixes as seen from the responder.
interface mem_responder_if;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_we_i;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;

    modport master (
        output mem_valid_i,
        output mem_addr_i,
        output mem_wdata_i,
        output mem_we_i,
        input  mem_ready_o,
        input  mem_rdata_o,
        input  mem_err_o
    );

    modport slave (
        input  mem_valid_i,
        input  mem_addr_i,
        input  mem_wdata_i,
        input  mem_we_i,
        output mem_ready_o,
        output mem_rdata_o,
        output mem_err_o
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a configurable number of wait states,
// byte-lane writes and an out-of-range error flag reported alongside ready.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WE_W    = 4;
    localparam int unsigned WORD_W  = 30;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   cap_word;
    logic [DATA_W-1:0]   cap_wdata;
    logic [WE_W-1:0]     cap_we;
    logic                ready_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH_WORDS];

    logic                accept;
    logic                enter_resp;
    logic [WORD_W-1:0]   src_word;
    logic [WE_W-1:0]     src_we;
    logic                src_oor;
    logic [IDX_W-1:0]    src_idx;
    logic                cap_oor;
    logic [IDX_W-1:0]    cap_idx;
    logic                unused_addr_lsb;

    // The transaction entering RESP comes straight from the bus when there are
    // no wait states, otherwise from the captured registers.
    always_comb begin
        accept     = 1'b0;
        enter_resp = 1'b0;
        src_word   = cap_word;
        src_we     = cap_we;
        if (state == ST_IDLE) begin
            accept   = bus.mem_valid_i;
            src_word = bus.mem_addr_i[31:2];
            src_we   = bus.mem_we_i;
        end
        if (accept && NO_WAIT) begin
            enter_resp = 1'b1;
        end
        if ((state == ST_WAIT) && (cnt == '0)) begin
            enter_resp = 1'b1;
        end
        src_oor = (src_word >= WORD_W'(DEPTH_WORDS));
        src_idx = src_word[IDX_W-1:0];
        cap_oor = (cap_word >= WORD_W'(DEPTH_WORDS));
        cap_idx = cap_word[IDX_W-1:0];
    end

    assign unused_addr_lsb = ^bus.mem_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_word  <= '0;
            cap_wdata <= '0;
            cap_we    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ready_q <= enter_resp;
            err_q   <= enter_resp && src_oor;
            if (enter_resp && (src_we == '0)) begin
                rdata_q <= src_oor ? '0 : mem[src_idx];
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_word  <= bus.mem_addr_i[31:2];
                        cap_wdata <= bus.mem_wdata_i;
                        cap_we    <= bus.mem_we_i;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Writes commit on the edge leaving RESP; a reset in that cycle drops them.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_RESP) && !cap_oor) begin
            for (int b = 0; b < int'(WE_W); b++) begin
                if (cap_we[b]) begin
                    mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_ready_o = ready_q;
    assign bus.mem_err_o   = err_q;
    assign bus.mem_rdata_o = rdata_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, minimum 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra wait states inserted before ready; range 0..15.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port mem_valid_i  input  1: initiator request valid.
REQ-006 SHALL have port mem_ready_o  output  1: one-cycle transaction-complete pulse.
REQ-007 SHALL have port mem_addr_i  input  32: byte address.
REQ-008 SHALL have port mem_wdata_i  input  32: write data; byte lane k is bits [8k+7:8k].
REQ-009 SHALL have port mem_we_i  input  4: byte write enables; 4'b0000 means read.
REQ-010 SHALL have port mem_rdata_o  output  32: read data.
REQ-011 SHALL have port mem_err_o  output  1: out-of-range flag, valid only while mem_ready_o=1.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, WAIT, RESP; reset state IDLE.
REQ-013 IDLE with mem_valid_i=1 SHALL accept the request and capture addr, wdata and we into internal registers on that edge.
REQ-014 On acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else to RESP.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP when it reads 0.
REQ-016 mem_ready_o SHALL be registered, high exactly in the RESP cycle, and low in every other cycle.
REQ-017 Latency: if the request is accepted in cycle N, mem_ready_o SHALL be high in cycle N+1+WAIT_CYCLES.
REQ-018 RESP SHALL always transition to IDLE; mem_valid_i in the RESP cycle SHALL be ignored.
REQ-019 A new request SHALL be acceptable no earlier than the cycle after RESP, giving a throughput of one transaction per 2+WAIT_CYCLES cycles.
REQ-020 Changes on mem_addr_i, mem_wdata_i, mem_we_i or mem_valid_i after acceptance SHALL NOT affect the pending transaction; deassertion of valid SHALL NOT abort it.
REQ-021 Word index SHALL be captured_addr[31:2]; addr[1:0] SHALL be ignored and no misalignment error SHALL be raised.
REQ-022 Out of range SHALL mean word index >= DEPTH_WORDS, including any nonzero address bits above the index width.
REQ-023 An in-range write SHALL update only the byte lanes whose we bit is set, on the clock edge ending the RESP cycle.
REQ-024 An in-range read SHALL present the stored word on mem_rdata_o during the RESP cycle, through a register loaded on the edge entering RESP.
REQ-025 mem_rdata_o SHALL hold its value until the next read response; write responses SHALL NOT change it.
REQ-026 An out-of-range write SHALL be dropped.
REQ-027 An out-of-range read SHALL return 32'h0.
REQ-028 Any out-of-range transaction SHALL assert mem_err_o together with mem_ready_o.
REQ-029 mem_err_o SHALL be 0 whenever mem_ready_o is 0.
REQ-030 A read following a write to the same word SHALL return the newly written data.

Reset
REQ-031 While rst=1 the FSM SHALL go to IDLE, with mem_ready_o=0, mem_err_o=0, mem_rdata_o=32'h0 and the wait counter at 0.
REQ-032 Reset asserted mid-transaction (in WAIT or RESP) SHALL discard the pending transaction, and its write SHALL NOT be committed.
REQ-033 Reset SHALL NOT clear memory contents; array contents after power-up are undefined.
REQ-034 mem_valid_i=1 in the cycle rst deasserts SHALL be accepted on the following edge, as in normal IDLE.

Verification
REQ-035 Bench SHALL cover, with WAIT_CYCLES=0: write 32'hDEADBEEF, we=4'hF, addr 0x10; valid rises in cycle 5 -> ready high in cycle 6 only; a subsequent read of 0x10 returns 32'hDEADBEEF, err=0.
REQ-036 Bench SHALL cover, with WAIT_CYCLES=3: a read accepted in cycle N -> ready high exactly in cycle N+4 and no other cycle; valid dropped at N+1 -> ready still high at N+4.
REQ-037 Bench SHALL cover byte lanes: word 0x20 holds 32'h11223344; write wdata 32'hAABBCCDD with we=4'b0101 -> read returns 32'h11BB33DD.
REQ-038 Bench SHALL cover out of range with DEPTH_WORDS=1024: read addr 0x1000 -> rdata 32'h0 and err=1 with ready; a write there followed by a read of word 0 -> word 0 unchanged.
REQ-039 Bench SHALL cover reset in WAIT: a write to 0x40 with WAIT_CYCLES=2 and rst pulsed in the cycle after acceptance -> no ready pulse, 0x40 retains its old value, rdata_o=0.
REQ-040 Bench SHALL cover back-to-back: valid held high continuously with WAIT_CYCLES=0 -> ready pulses every 2nd cycle, and each pulse corresponds to a separate accepted transaction.
